// File: rtl/i2c_write_sequencer.sv
// I2C write sequencer: queues {slave address, data byte} requests and hands them to the
// I2C master one at a time, reporting ok / NACK / timeout. Optional macro: I2C_SEQ_RETRY_EN.
module i2c_write_sequencer #(
  parameter int DEPTH       = 4,
  parameter int TIMEOUT_CYC = 4096,
  parameter int MAX_RETRY   = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [6:0]             in_addr,
  input  logic [7:0]             in_data,
  output logic                   in_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic                   m_start,
  output logic [6:0]             m_addr,
  output logic [7:0]             m_data,
  input  logic                   m_done,
  input  logic                   m_nack,
  output logic                   st_valid,
  output logic                   st_nack,
  output logic                   st_tmo,
  output logic                   busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t        state, state_nxt;
  logic [14:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level_nxt;
  logic [TW-1:0] timer;
  logic          push, pop, retry, timed_out;

  assign push      = in_valid && in_ready;
  assign pop       = (state == IDLE) && (level != '0);
  assign timed_out = (timer == TMO_LAST);

  // FIFO: in_ready is registered from the next level, so a full FIFO refuses a push
  // even when the sequencer pops in the same cycle.
  always_comb begin
    level_nxt = level;
    if (push && !pop)
      level_nxt = level + 1'b1;
    else if (!push && pop)
      level_nxt = level - 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      in_ready <= 1'b1;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      level    <= level_nxt;
      in_ready <= (level_nxt != FULL_LVL);
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= {in_addr, in_data};
  end

`ifdef I2C_SEQ_RETRY_EN
  localparam int RW = $clog2(MAX_RETRY + 2);
  logic [RW-1:0] retries;

  assign retry = m_done && m_nack && (retries < RW'(MAX_RETRY));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      retries <= '0;
    else if (state == IDLE)
      retries <= '0;
    else if (state == WAIT && retry)
      retries <= retries + 1'b1;
  end
`else
  // Retries are compiled out; a negative MAX_RETRY is never legal, so this is constant 0.
  assign retry = m_done && m_nack && (MAX_RETRY < 0);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pop) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT: begin
        if (m_done)
          state_nxt = retry ? ISSUE : DONE;
        else if (timed_out)
          state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    m_start  = 1'b0;
    st_valid = 1'b0;
    busy     = 1'b1;
    case (state)
      IDLE:    busy     = 1'b0;
      ISSUE:   m_start  = 1'b1;
      DONE:    st_valid = 1'b1;
      default: ;
    endcase
  end

  // Timer counts the ISSUE cycle as its first tick, so the abort lands TIMEOUT_CYC
  // cycles after m_start; it saturates instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_addr  <= '0;
      m_data  <= '0;
      timer   <= '0;
      st_nack <= 1'b0;
      st_tmo  <= 1'b0;
    end else begin
      case (state)
        IDLE:  if (pop) {m_addr, m_data} <= mem[rd_ptr];
        ISSUE: timer <= TW'(1);
        WAIT: begin
          if (timer != '1)
            timer <= timer + 1'b1;
          if (m_done && !retry) begin
            st_nack <= m_nack;
            st_tmo  <= 1'b0;
          end else if (!m_done && timed_out) begin
            st_nack <= 1'b0;
            st_tmo  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_write_sequencer.sv
// Bench for i2c_write_sequencer: directed scenarios plus a randomized run against a
// queue-based model of request order, retry count and final status.
module tb_i2c_write_sequencer;
  localparam int DEPTH     = 4;
  localparam int TMO_MAIN  = 64;
  localparam int TMO_SHORT = 16;
  localparam int MAX_RETRY = 2;
`ifdef I2C_SEQ_RETRY_EN
  localparam int ATTEMPTS_ON_NACK = MAX_RETRY + 1;
`else
  localparam int ATTEMPTS_ON_NACK = 1;
`endif

  typedef struct { int cyc; logic [6:0] a; logic [7:0] d; } start_t;
  typedef struct { int cyc; logic n; logic t; } stat_t;
  typedef struct { logic [6:0] a; logic [7:0] d; } req_t;

  logic clk, reset, in_valid, m_done, m_nack;
  logic [6:0] in_addr;
  logic [7:0] in_data;
  logic in_ready, m_start, st_valid, st_nack, st_tmo, busy;
  logic [2:0] level;
  logic [6:0] m_addr;
  logic [7:0] m_data;
  logic t_in_ready, t_m_start, t_st_valid, t_st_nack, t_st_tmo, t_busy;
  logic [2:0] t_level;
  logic [6:0] t_m_addr;
  logic [7:0] t_m_data;

  int checks = 0, failures = 0;
  int cyc = 0, hold_err = 0;
  start_t start_q[$];
  stat_t  stat_q[$];
  int     tstart_q[$];
  stat_t  tstat_q[$];
  logic   resp_q[$];
  int     mode = 0, cfg_dly = 1;
  logic   cfg_nack = 1'b0;

  i2c_write_sequencer #(.DEPTH(DEPTH), .TIMEOUT_CYC(TMO_MAIN), .MAX_RETRY(MAX_RETRY)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_addr(in_addr), .in_data(in_data),
    .in_ready(in_ready), .level(level), .m_start(m_start), .m_addr(m_addr), .m_data(m_data),
    .m_done(m_done), .m_nack(m_nack), .st_valid(st_valid), .st_nack(st_nack),
    .st_tmo(st_tmo), .busy(busy));

  i2c_write_sequencer #(.DEPTH(DEPTH), .TIMEOUT_CYC(TMO_SHORT), .MAX_RETRY(MAX_RETRY)) u_tmo (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_addr(in_addr), .in_data(in_data),
    .in_ready(t_in_ready), .level(t_level), .m_start(t_m_start), .m_addr(t_m_addr),
    .m_data(t_m_data), .m_done(m_done), .m_nack(m_nack), .st_valid(t_st_valid),
    .st_nack(t_st_nack), .st_tmo(t_st_tmo), .busy(t_busy));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Event log: one cycle index per posedge, outputs sampled 1 time unit later.
  start_t mon_s;
  stat_t  mon_t;
  logic   holding = 1'b0;
  logic [6:0] ha;
  logic [7:0] hd;
  always begin
    @(posedge clk);
    #1;
    cyc++;
    if (reset) begin
      holding = 1'b0;
    end else begin
      if (holding && (m_addr !== ha || m_data !== hd))
        hold_err++;
      if (m_start) begin
        mon_s.cyc = cyc; mon_s.a = m_addr; mon_s.d = m_data;
        start_q.push_back(mon_s);
        ha = m_addr; hd = m_data; holding = 1'b1;
      end
      if (st_valid) begin
        mon_t.cyc = cyc; mon_t.n = st_nack; mon_t.t = st_tmo;
        stat_q.push_back(mon_t);
        holding = 1'b0;
      end
      if (t_m_start)
        tstart_q.push_back(cyc);
      if (t_st_valid) begin
        mon_t.cyc = cyc; mon_t.n = t_st_nack; mon_t.t = t_st_tmo;
        tstat_q.push_back(mon_t);
      end
    end
  end

  // Master model: mode 0 never answers, 1 answers after cfg_dly cycles, 2 random.
  int cnt = 0;
  always @(negedge clk) begin
    m_done = 1'b0;
    m_nack = 1'b0;
    if (reset) begin
      cnt = 0;
    end else begin
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          m_done = 1'b1;
          m_nack = (mode == 2) ? 1'($urandom_range(0, 1)) : cfg_nack;
          resp_q.push_back(m_nack);
        end
      end
      if (m_start && mode != 0)
        cnt = (mode == 2) ? int'($urandom_range(1, 12)) : cfg_dly;
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic push_one(input logic [6:0] a, input logic [7:0] d, output bit acc);
    in_valid = 1'b1; in_addr = a; in_data = d;
    acc = in_ready;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_stat(input int base, input int n, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      if (stat_q.size() >= base + n) ok = 1'b1;
      else @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (level !== 3'd0) begin failures++; $display("FAIL rst_level got %0d exp 0", level); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got %0b exp 1", in_ready); end
    checks++; if ({m_start, m_addr, m_data} !== 16'h0) begin failures++; $display("FAIL rst_master got %0h exp 0", {m_start, m_addr, m_data}); end
    checks++; if ({st_valid, st_nack, st_tmo, busy} !== 4'b0) begin failures++; $display("FAIL rst_status got %b exp 0000", {st_valid, st_nack, st_tmo, busy}); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    int sb, tb, t0; bit acc, ok;
    do_reset();
    mode = 1; cfg_dly = 20; cfg_nack = 1'b0;
    sb = start_q.size(); tb = stat_q.size(); t0 = cyc;
    push_one(7'h50, 8'hA5, acc);
    wait_stat(tb, 1, 100, ok);
    checks++; if (!ok) begin failures++; $display("FAIL single_status_seen got 0 exp 1"); return; end
    checks++; if (start_q.size() - sb != 1) begin failures++; $display("FAIL single_starts got %0d exp 1", start_q.size() - sb); end
    checks++; if (start_q[sb].cyc != t0 + 2) begin failures++; $display("FAIL single_latency got %0d exp %0d", start_q[sb].cyc - t0, 2); end
    checks++; if (start_q[sb].a !== 7'h50 || start_q[sb].d !== 8'hA5) begin failures++; $display("FAIL single_payload got %h/%h exp 50/a5", start_q[sb].a, start_q[sb].d); end
    checks++; if (stat_q[tb].cyc != start_q[sb].cyc + 21) begin failures++; $display("FAIL single_done_cycle got %0d exp %0d", stat_q[tb].cyc - start_q[sb].cyc, 21); end
    checks++; if (stat_q[tb].n !== 1'b0 || stat_q[tb].t !== 1'b0) begin failures++; $display("FAIL single_status got n=%b t=%b exp n=0 t=0", stat_q[tb].n, stat_q[tb].t); end
    checks++; if (hold_err != 0) begin failures++; $display("FAIL single_hold got %0d exp 0", hold_err); end
  endtask

  task automatic test_fifo_full();
    req_t exp_q[$]; req_t r; int sb, tb; bit acc, ok;
    do_reset();
    mode = 1; cfg_dly = 30; cfg_nack = 1'b0;
    sb = start_q.size(); tb = stat_q.size();
    for (int i = 0; i < DEPTH + 2; i++) begin
      r.a = 7'($urandom); r.d = 8'(i);
      push_one(r.a, r.d, acc);
      checks++; if (acc !== (i < DEPTH + 1)) begin failures++; $display("FAIL full_accept[%0d] got %0b exp %0b", i, acc, i < DEPTH + 1); end
      if (acc) exp_q.push_back(r);
    end
    checks++; if (level !== 3'(DEPTH) || in_ready !== 1'b0) begin failures++; $display("FAIL full_level got %0d/%0b exp %0d/0", level, in_ready, DEPTH); end
    wait_stat(tb, exp_q.size(), 400, ok);
    checks++; if (!ok || start_q.size() - sb != exp_q.size()) begin failures++; $display("FAIL full_drain got %0d exp %0d", start_q.size() - sb, exp_q.size()); return; end
    foreach (exp_q[k]) begin
      checks++; if (start_q[sb+k].a !== exp_q[k].a || start_q[sb+k].d !== exp_q[k].d) begin failures++; $display("FAIL full_order[%0d] got %h/%h exp %h/%h", k, start_q[sb+k].a, start_q[sb+k].d, exp_q[k].a, exp_q[k].d); end
    end
    @(negedge clk);
    checks++; if (level !== 3'd0) begin failures++; $display("FAIL full_empty_level got %0d exp 0", level); end
  endtask

  task automatic test_timeout();
    int sb, tb, tsb, ttb; bit acc; bit ok = 1'b0;
    do_reset();
    mode = 0;
    sb = start_q.size(); tb = stat_q.size(); tsb = tstart_q.size(); ttb = tstat_q.size();
    push_one(7'h11, 8'h22, acc);
    push_one(7'h33, 8'h44, acc);
    for (int i = 0; i < 400 && !ok; i++) begin
      if (stat_q.size() >= tb + 2 && tstat_q.size() >= ttb + 2) ok = 1'b1;
      else @(negedge clk);
    end
    checks++; if (!ok) begin failures++; $display("FAIL tmo_seen got 0 exp 1"); return; end
    checks++; if (tstat_q[ttb].cyc - tstart_q[tsb] != TMO_SHORT) begin failures++; $display("FAIL tmo16_cycles got %0d exp %0d", tstat_q[ttb].cyc - tstart_q[tsb], TMO_SHORT); end
    checks++; if (tstat_q[ttb].t !== 1'b1 || tstat_q[ttb].n !== 1'b0) begin failures++; $display("FAIL tmo16_status got t=%b n=%b exp t=1 n=0", tstat_q[ttb].t, tstat_q[ttb].n); end
    checks++; if (tstart_q[tsb+1] - tstat_q[ttb].cyc != 2) begin failures++; $display("FAIL tmo16_next_issue got %0d exp 2", tstart_q[tsb+1] - tstat_q[ttb].cyc); end
    checks++; if (stat_q[tb].cyc - start_q[sb].cyc != TMO_MAIN || stat_q[tb].t !== 1'b1) begin failures++; $display("FAIL tmo64 got %0d t=%b exp %0d t=1", stat_q[tb].cyc - start_q[sb].cyc, stat_q[tb].t, TMO_MAIN); end
    checks++; if (start_q[sb+1].a !== 7'h33 || start_q[sb+1].d !== 8'h44) begin failures++; $display("FAIL tmo_second got %h/%h exp 33/44", start_q[sb+1].a, start_q[sb+1].d); end
  endtask

  task automatic test_nack();
    int sb, tb; bit acc, ok;
    do_reset();
    mode = 1; cfg_dly = 4; cfg_nack = 1'b1;
    sb = start_q.size(); tb = stat_q.size();
    push_one(7'h2A, 8'h5C, acc);
    wait_stat(tb, 1, 200, ok);
    repeat (3) @(negedge clk);
    checks++; if (!ok) begin failures++; $display("FAIL nack_seen got 0 exp 1"); return; end
    checks++; if (start_q.size() - sb != ATTEMPTS_ON_NACK) begin failures++; $display("FAIL nack_attempts got %0d exp %0d", start_q.size() - sb, ATTEMPTS_ON_NACK); end
    checks++; if (stat_q[tb].n !== 1'b1 || stat_q[tb].t !== 1'b0) begin failures++; $display("FAIL nack_status got n=%b t=%b exp n=1 t=0", stat_q[tb].n, stat_q[tb].t); end
    for (int k = sb; k < start_q.size(); k++) begin
      checks++; if (start_q[k].a !== 7'h2A || start_q[k].d !== 8'h5C) begin failures++; $display("FAIL nack_payload[%0d] got %h/%h exp 2a/5c", k - sb, start_q[k].a, start_q[k].d); end
    end
  endtask

  task automatic test_reset_mid();
    int sb, tb; bit acc;
    do_reset();
    mode = 0;
    for (int i = 0; i < 3; i++) push_one(7'(i + 1), 8'(i + 8'h10), acc);
    repeat (4) @(negedge clk);
    checks++; if (level !== 3'd2 || busy !== 1'b1) begin failures++; $display("FAIL mid_pre got level=%0d busy=%b exp 2/1", level, busy); end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++; if ({level, in_ready, m_start, m_addr, m_data, st_valid, st_nack, st_tmo, busy} !== {3'd0, 1'b1, 16'h0, 4'h0}) begin
      failures++; $display("FAIL mid_reset_outputs got %h exp %h", {level, in_ready, m_start, m_addr, m_data, st_valid, st_nack, st_tmo, busy}, {3'd0, 1'b1, 16'h0, 4'h0}); end
    @(negedge clk);
    reset = 1'b0;
    sb = start_q.size(); tb = stat_q.size();
    repeat (20) @(negedge clk);
    checks++; if (start_q.size() != sb || stat_q.size() != tb) begin failures++; $display("FAIL mid_quiet got starts=%0d stats=%0d exp 0/0", start_q.size() - sb, stat_q.size() - tb); end
    checks++; if (level !== 3'd0 || busy !== 1'b0) begin failures++; $display("FAIL mid_flushed got level=%0d busy=%b exp 0/0", level, busy); end
  endtask

  task automatic test_full_pop();
    req_t exp_q[$]; req_t r; int sb, tb; bit acc; bit ok = 1'b0;
    do_reset();
    mode = 1; cfg_dly = 10; cfg_nack = 1'b0;
    sb = start_q.size(); tb = stat_q.size();
    for (int i = 0; i < DEPTH + 1; i++) begin
      r.a = 7'($urandom); r.d = 8'($urandom);
      push_one(r.a, r.d, acc);
      if (acc) exp_q.push_back(r);
    end
    for (int i = 0; i < 100 && !ok; i++) begin
      if (st_valid) ok = 1'b1;
      else @(negedge clk);
    end
    @(negedge clk);
    checks++; if (!ok || level !== 3'(DEPTH) || in_ready !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL fullpop_pre got level=%0d ready=%b busy=%b exp %0d/0/0", level, in_ready, busy, DEPTH); end
    push_one(7'h7F, 8'hEE, acc);
    checks++; if (acc !== 1'b0 || level !== 3'(DEPTH - 1)) begin failures++; $display("FAIL fullpop_refused got acc=%b level=%0d exp 0/%0d", acc, level, DEPTH - 1); end
    wait_stat(tb, exp_q.size(), 300, ok);
    checks++; if (!ok || start_q.size() - sb != exp_q.size()) begin failures++; $display("FAIL fullpop_drain got %0d exp %0d", start_q.size() - sb, exp_q.size()); return; end
    foreach (exp_q[k]) begin
      checks++; if (start_q[sb+k].a !== exp_q[k].a || start_q[sb+k].d !== exp_q[k].d) begin failures++; $display("FAIL fullpop_order[%0d] got %h/%h exp %h/%h", k, start_q[sb+k].a, start_q[sb+k].d, exp_q[k].a, exp_q[k].d); end
    end
  endtask

  task automatic test_random();
    req_t exp_q[$]; req_t r; int sb, tb, rb, si, ri, att, prev_stat; bit ok; logic nk;
    do_reset();
    mode = 2;
    sb = start_q.size(); tb = stat_q.size(); rb = resp_q.size();
    for (int i = 0; i < 300; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_addr = 7'($urandom); in_data = 8'($urandom);
      if (in_valid && in_ready) begin r.a = in_addr; r.d = in_data; exp_q.push_back(r); end
      @(negedge clk);
    end
    in_valid = 1'b0;
    wait_stat(tb, exp_q.size(), 5000, ok);
    repeat (3) @(negedge clk);
    checks++; if (!ok || stat_q.size() - tb != exp_q.size()) begin failures++; $display("FAIL rand_status_count got %0d exp %0d", stat_q.size() - tb, exp_q.size()); return; end
    si = sb; ri = rb; prev_stat = -100;
    foreach (exp_q[k]) begin
      att = 0;
      nk = 1'b0;
      while (1) begin
        if (si >= start_q.size() || ri >= resp_q.size()) begin failures++; $display("FAIL rand_missing_start[%0d] got none exp one", k); return; end
        checks++; if (start_q[si].a !== exp_q[k].a || start_q[si].d !== exp_q[k].d) begin failures++; $display("FAIL rand_order[%0d] got %h/%h exp %h/%h", k, start_q[si].a, start_q[si].d, exp_q[k].a, exp_q[k].d); end
        if (att == 0) begin
          checks++; if (start_q[si].cyc < prev_stat + 2) begin failures++; $display("FAIL rand_gap[%0d] got %0d exp >=2", k, start_q[si].cyc - prev_stat); end
        end
        si++; nk = resp_q[ri]; ri++; att++;
        if (!nk || att >= ATTEMPTS_ON_NACK) break;
      end
      checks++; if (stat_q[tb+k].n !== nk || stat_q[tb+k].t !== 1'b0) begin failures++; $display("FAIL rand_status[%0d] got n=%b t=%b exp n=%b t=0", k, stat_q[tb+k].n, stat_q[tb+k].t, nk); end
      prev_stat = stat_q[tb+k].cyc;
    end
    checks++; if (si != start_q.size() || level !== 3'd0) begin failures++; $display("FAIL rand_tail got extra=%0d level=%0d exp 0/0", start_q.size() - si, level); end
    checks++; if (hold_err != 0) begin failures++; $display("FAIL rand_hold got %0d exp 0", hold_err); end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_addr = '0; in_data = '0;
    repeat (2) @(negedge clk);
    test_reset();
    test_single();
    test_fifo_full();
    test_timeout();
    test_nack();
    test_reset_mid();
    test_full_pop();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
